// File: rtl/ikaopll_slot_sequencer.sv
// Slot timing controller: divides master ticks into the slot-SR shift enable,
// tracks the operator slot and defers CPU writes to a fixed slot window.
// Optional one-entry write queue: define IKAOPLL_WR_QUEUE_EN.
module ikaopll_slot_sequencer #(
  parameter int DIV     = 4,
  parameter int SLOTS   = 18,
  parameter int WR_SLOT = 0
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST_n,
  input  logic       i_PHIM_CEN_n,
  input  logic       i_IC_n,
  input  logic       i_WR_REQ,
  output logic       o_CEN_n,
  output logic [4:0] o_SLOT,
  output logic       o_CYCLE_LAST,
  output logic       o_WR_BUSY,
  output logic       o_LATCH_EN
);

  localparam logic [3:0] PRE_LAST    = 4'(DIV - 1);
  localparam logic [4:0] SLOT_LAST   = 5'(SLOTS - 1);
  localparam logic [4:0] WR_SLOT_IDX = 5'(WR_SLOT);

  typedef enum logic {
    IDLE,
    PEND
  } wr_state_t;

  wr_state_t  wr_state, wr_state_nxt;
  logic [3:0] prescaler;
  logic       master_tick;
  logic       shift_fire;
  logic       strobe;

`ifdef IKAOPLL_WR_QUEUE_EN
  logic       queued, queued_nxt;
`endif

  assign master_tick = ~i_PHIM_CEN_n;
  assign shift_fire  = master_tick && (prescaler == PRE_LAST);

  // The prescaler keeps running through initial-clear so downstream SRs flush.
  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      prescaler <= 4'd0;
      o_CEN_n   <= 1'b1;
    end else begin
      if (master_tick)
        prescaler <= (prescaler == PRE_LAST) ? 4'd0 : prescaler + 4'd1;
      o_CEN_n <= ~shift_fire;
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n)
      o_SLOT <= 5'd0;
    else if (!i_IC_n)
      o_SLOT <= 5'd0;
    else if (!o_CEN_n)
      o_SLOT <= (o_SLOT == SLOT_LAST) ? 5'd0 : o_SLOT + 5'd1;
  end

  assign o_CYCLE_LAST = (o_SLOT == SLOT_LAST);

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      wr_state <= IDLE;
`ifdef IKAOPLL_WR_QUEUE_EN
      queued   <= 1'b0;
`endif
    end else begin
      wr_state <= wr_state_nxt;
`ifdef IKAOPLL_WR_QUEUE_EN
      queued   <= queued_nxt;
`endif
    end
  end

  // The latch strobe coincides with the shift edge of the write slot.
  assign strobe = (wr_state == PEND) && !o_CEN_n && (o_SLOT == WR_SLOT_IDX);

  always_comb begin
    wr_state_nxt = wr_state;
    o_LATCH_EN   = 1'b0;
    o_WR_BUSY    = 1'b0;
`ifdef IKAOPLL_WR_QUEUE_EN
    queued_nxt   = queued;
`endif
    if (!i_IC_n) begin
      wr_state_nxt = IDLE;
`ifdef IKAOPLL_WR_QUEUE_EN
      queued_nxt   = 1'b0;
`endif
    end else begin
      case (wr_state)
        IDLE: begin
          if (i_WR_REQ)
            wr_state_nxt = PEND;
        end
        PEND: begin
`ifdef IKAOPLL_WR_QUEUE_EN
          o_WR_BUSY = queued;
          if (strobe) begin
            o_LATCH_EN   = 1'b1;
            wr_state_nxt = (queued || i_WR_REQ) ? PEND : IDLE;
            queued_nxt   = 1'b0;
          end else if (i_WR_REQ) begin
            queued_nxt = 1'b1;
          end
`else
          o_WR_BUSY = 1'b1;
          if (strobe) begin
            o_LATCH_EN   = 1'b1;
            wr_state_nxt = IDLE;
          end
`endif
        end
        default: wr_state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ikaopll_slot_sequencer.sv
// Directed self-checking bench for ikaopll_slot_sequencer at default parameters
// (IKAOPLL_WR_QUEUE_EN undefined).
module tb_ikaopll_slot_sequencer;

  logic       i_EMUCLK     = 1'b0;
  logic       i_RST_n      = 1'b0;
  logic       i_PHIM_CEN_n = 1'b1;
  logic       i_IC_n       = 1'b1;
  logic       i_WR_REQ     = 1'b0;
  logic       o_CEN_n;
  logic [4:0] o_SLOT;
  logic       o_CYCLE_LAST;
  logic       o_WR_BUSY;
  logic       o_LATCH_EN;

  int test_count = 0;
  int fail_count = 0;
  int last_count;
  int latch_count;

  ikaopll_slot_sequencer #(.DIV(4), .SLOTS(18), .WR_SLOT(0)) dut (
    .i_EMUCLK    (i_EMUCLK),
    .i_RST_n     (i_RST_n),
    .i_PHIM_CEN_n(i_PHIM_CEN_n),
    .i_IC_n      (i_IC_n),
    .i_WR_REQ    (i_WR_REQ),
    .o_CEN_n     (o_CEN_n),
    .o_SLOT      (o_SLOT),
    .o_CYCLE_LAST(o_CYCLE_LAST),
    .o_WR_BUSY   (o_WR_BUSY),
    .o_LATCH_EN  (o_LATCH_EN)
  );

  always #5 i_EMUCLK = ~i_EMUCLK;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    test_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic phim_n, input logic ic_n, input logic wr_req);
    i_PHIM_CEN_n = phim_n;
    i_IC_n       = ic_n;
    i_WR_REQ     = wr_req;
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic step();
    @(negedge i_EMUCLK);
  endtask

  task automatic resetDut();
    i_RST_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (2) step();
    applyStimulus(1'b0, 1'b1, 1'b0);
    i_RST_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset values
    step();
    checkOutput("rst_cen_n", 32'(o_CEN_n), 32'd1);
    checkOutput("rst_slot", 32'(o_SLOT), 32'd0);
    checkOutput("rst_cycle_last", 32'(o_CYCLE_LAST), 32'd0);
    checkOutput("rst_busy", 32'(o_WR_BUSY), 32'd0);
    checkOutput("rst_latch", 32'(o_LATCH_EN), 32'd0);

    // Free-running master tick: pulse every 4th clock, slot rotation of 72
    resetDut();
    last_count = 0;
    for (int n = 1; n <= 80; n++) begin
      step();
      checkOutput($sformatf("run_cen_n@%0d", n), 32'(o_CEN_n), (n % 4 == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("run_slot@%0d", n), 32'(o_SLOT), 32'(((n - 1) / 4) % 18));
      if (n <= 72 && o_CYCLE_LAST) last_count++;
    end
    checkOutput("cycle_last_width", 32'(last_count), 32'd4);

    // Master tick one cycle in three: pulse every 12 clocks
    resetDut();
    for (int n = 1; n <= 60; n++) begin
      applyStimulus((n % 3 == 0) ? 1'b0 : 1'b1, 1'b1, 1'b0);
      step();
      checkOutput($sformatf("div3_cen_n@%0d", n), 32'(o_CEN_n), (n % 12 == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("div3_slot@%0d", n), 32'(o_SLOT), 32'((n - 1) / 12));
    end
    // Master tick held off: only the already-registered shift lands
    for (int n = 61; n <= 70; n++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      step();
      checkOutput($sformatf("frozen_cen_n@%0d", n), 32'(o_CEN_n), 32'd1);
      checkOutput($sformatf("frozen_slot@%0d", n), 32'(o_SLOT), 32'd5);
    end

    // Write at slot 5 strobes at slot 0; a second request while busy is dropped
    resetDut();
    latch_count = 0;
    for (int n = 1; n <= 150; n++) begin
      applyStimulus(1'b0, 1'b1, (n == 22 || n == 40));
      step();
      checkOutput($sformatf("wr_busy@%0d", n), 32'(o_WR_BUSY), (n >= 22 && n <= 76) ? 32'd1 : 32'd0);
      checkOutput($sformatf("wr_latch@%0d", n), 32'(o_LATCH_EN), (n == 76) ? 32'd1 : 32'd0);
      if (o_LATCH_EN) latch_count++;
    end
    checkOutput("wr_latch_count", 32'(latch_count), 32'd1);

    // Initial-clear for 20 clocks with a write pending at slot 9
    resetDut();
    for (int n = 1; n <= 80; n++) begin
      applyStimulus(1'b0, (n >= 39 && n <= 58) ? 1'b0 : 1'b1, (n == 37));
      step();
      checkOutput($sformatf("ic_cen_n@%0d", n), 32'(o_CEN_n), (n % 4 == 0) ? 32'd0 : 32'd1);
      checkOutput($sformatf("ic_busy@%0d", n), 32'(o_WR_BUSY), (n == 37 || n == 38) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ic_latch@%0d", n), 32'(o_LATCH_EN), 32'd0);
      if (n <= 38)
        checkOutput($sformatf("ic_slot@%0d", n), 32'(o_SLOT), 32'((n - 1) / 4));
      else if (n <= 58)
        checkOutput($sformatf("ic_slot@%0d", n), 32'(o_SLOT), 32'd0);
      else
        checkOutput($sformatf("ic_slot@%0d", n), 32'(o_SLOT), 32'((n - 57) / 4));
    end

    // Asynchronous reset between edges while a write is pending
    resetDut();
    for (int n = 1; n <= 45; n++) begin
      applyStimulus(1'b0, 1'b1, (n == 30));
      step();
    end
    checkOutput("async_pre_busy", 32'(o_WR_BUSY), 32'd1);
    checkOutput("async_pre_slot", 32'(o_SLOT), 32'd11);
    @(posedge i_EMUCLK);
    #2;
    i_RST_n = 1'b0;
    #1;
    checkOutput("async_cen_n", 32'(o_CEN_n), 32'd1);
    checkOutput("async_slot", 32'(o_SLOT), 32'd0);
    checkOutput("async_cycle_last", 32'(o_CYCLE_LAST), 32'd0);
    checkOutput("async_busy", 32'(o_WR_BUSY), 32'd0);
    checkOutput("async_latch", 32'(o_LATCH_EN), 32'd0);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
